// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the handshaked pipeline register (pipe_reg_hs).
// Holds the slice state encoding, the supported depth limit and the helper
// that sizes the occupancy counter.
package pipe_reg_pkg;

   // Deepest chain the occupancy counter and the checks are sized for
   localparam int STAGES_MAX = 4;

   // Per-slice holding state; SKID is only reachable when the skid entry exists
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } slice_state_t;

   // Occupancy counter width: the chain can hold up to two beats per slice
   function automatic int OCC_W(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// One handshaked pipeline slice of pipe_reg_hs.
// Carries a data payload and a control bundle; control is forced to zero
// whenever the slice holds no valid beat, so bubbles never have side effects.
// Flush empties the slice and clears control but leaves data untouched.
// Build option PIPE_REG_HS_SKID_EN: when defined the slice has a main and a
// skid entry with a registered ready (no out_ready -> in_ready path); when
// undefined it is a single entry whose ready looks through to downstream.
module pipe_reg_slice
   import pipe_reg_pkg::*;
#(
   parameter int DATA_W = 72,
   parameter int CTRL_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   slice_state_t      state;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              accept;
   logic              drain;

   // The main entry always faces downstream; control is masked when empty
   assign out_valid = (state != EMPTY);
   assign out_data  = main_data;
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

`ifdef PIPE_REG_HS_SKID_EN

   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              ready_q;

   // Ready is a flop so that downstream back-pressure never reaches upstream
   // combinationally; it is low only while the skid entry is occupied
   assign in_ready = ready_q;

   // Slice FSM: the main entry drains first and the skid entry refills it,
   // so beat order is preserved while absorbing one beat of back-pressure
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
         ready_q   <= 1'b0;
      end else if (flush) begin
         state     <= EMPTY;
         main_ctrl <= '0;
         skid_ctrl <= '0;
         ready_q   <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               ready_q <= 1'b1;
               if (accept) begin
                  state     <= FULL;
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
               end
            end
            FULL: begin
               if (accept && !drain) begin
                  state     <= SKID;
                  skid_data <= in_data;
                  skid_ctrl <= in_ctrl;
                  ready_q   <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
                  if (accept) begin
                     main_data <= in_data;
                     main_ctrl <= in_ctrl;
                  end else if (drain) begin
                     state <= EMPTY;
                  end
               end
            end
            SKID: begin
               if (drain) begin
                  state     <= FULL;
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
                  skid_ctrl <= '0;
                  ready_q   <= 1'b1;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

`else

   logic alive;

   // A full slice can still accept when its beat leaves on the same edge;
   // alive keeps ready low through reset and for the first cycle after it
   assign in_ready = alive && (!out_valid || out_ready);

   // Single-entry slice: EMPTY/FULL with load-on-accept, empty-on-drain
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         main_data <= '0;
         main_ctrl <= '0;
         alive     <= 1'b0;
      end else if (flush) begin
         state     <= EMPTY;
         main_ctrl <= '0;
         alive     <= 1'b1;
      end else begin
         alive <= 1'b1;
         if (accept) begin
            state     <= FULL;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
         end else if (drain) begin
            state <= EMPTY;
         end
      end
   end

`endif

endmodule

// File: rtl/pipe_reg_hs.sv
// Parametrised handshaked pipeline register (replacement for the EX/MEM latch).
// Chains STAGES pipe_reg_slice instances with valid/ready back-pressure,
// flush and zero-control bubbles, and tracks how many beats are in flight.
// Build option PIPE_REG_HS_SKID_EN selects two-entry skid slices with a
// registered ready; without it each slice holds one beat.
module pipe_reg_hs
   import pipe_reg_pkg::*;
#(
   parameter int DATA_W = 72,
   parameter int CTRL_W = 5,
   parameter int STAGES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [CTRL_W-1:0]          in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [OCC_W(STAGES)-1:0]   occupancy
);

   localparam int OW = OCC_W(STAGES);
   localparam logic [OW-1:0] OCC_ONE = 1;

   // Refuse to build a chain depth the counter and slices are not sized for
   if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("pipe_reg_hs: STAGES must be within 1..%0d", STAGES_MAX);
   end

   logic in_fire;
   logic out_fire;

   // Each slice keeps its own link signals so the ready chain is a plain
   // series of nets rather than one vector feeding back into itself
   for (genvar i = 0; i < STAGES; i++) begin : g_slice
      logic              up_valid;
      logic              up_ready;
      logic [DATA_W-1:0] up_data;
      logic [CTRL_W-1:0] up_ctrl;
      logic              dn_valid;
      logic              dn_ready;
      logic [DATA_W-1:0] dn_data;
      logic [CTRL_W-1:0] dn_ctrl;

      if (i == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_data  = in_data;
         assign up_ctrl  = in_ctrl;
      end else begin : g_link
         assign up_valid = g_slice[i-1].dn_valid;
         assign up_data  = g_slice[i-1].dn_data;
         assign up_ctrl  = g_slice[i-1].dn_ctrl;
      end

      if (i == STAGES - 1) begin : g_last
         assign dn_ready = out_ready;
      end else begin : g_next
         assign dn_ready = g_slice[i+1].up_ready;
      end

      pipe_reg_slice #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_slice (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .in_valid  (up_valid),
         .in_ready  (up_ready),
         .in_data   (up_data),
         .in_ctrl   (up_ctrl),
         .out_valid (dn_valid),
         .out_ready (dn_ready),
         .out_data  (dn_data),
         .out_ctrl  (dn_ctrl)
      );
   end

   assign in_ready  = g_slice[0].up_ready;
   assign out_valid = g_slice[STAGES-1].dn_valid;
   assign out_data  = g_slice[STAGES-1].dn_data;
   assign out_ctrl  = g_slice[STAGES-1].dn_ctrl;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Beats in flight: count transfers at both ends; flush and reset empty it
   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occupancy <= occupancy + OCC_ONE;
            2'b01:   occupancy <= occupancy - OCC_ONE;
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Self-checking bench for pipe_reg_hs.
// Three instances (STAGES = 1, 2, 3) share one stimulus stream; each has its
// own scoreboard: an array of accepted beats that must come out in order,
// whose length is the expected occupancy. Works with PIPE_REG_HS_SKID_EN
// defined or undefined.
module tb_pipe_reg_hs;

   localparam int DW = 72;
   localparam int CW = 5;
   localparam int ND = 3;

`ifdef PIPE_REG_HS_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_ready;

   logic          ir  [ND];
   logic          ov  [ND];
   logic [DW-1:0] od  [ND];
   logic [CW-1:0] oc  [ND];
   logic [2:0]    occ [ND];
   logic [1:0]    occ1;
   logic [2:0]    occ2;
   logic [2:0]    occ3;

   // Scoreboard: per instance, beats accepted but not yet delivered
   logic [DW+CW-1:0] mem [ND][16];
   int head [ND];
   int tail [ND];

   int cyc;
   int accCnt [ND];
   int popCnt [ND];
   int firstAcc [ND];
   int lastAcc [ND];
   int firstPop [ND];
   int lastPop [ND];

   int total;
   int bad;

   // Free-running clock
   always #5 clk = ~clk;

   pipe_reg_hs #(.DATA_W(DW), .CTRL_W(CW), .STAGES(1)) u1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
      .occupancy(occ1));

   pipe_reg_hs #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) u2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
      .occupancy(occ2));

   pipe_reg_hs #(.DATA_W(DW), .CTRL_W(CW), .STAGES(3)) u3 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]),
      .occupancy(occ3));

   assign occ[0] = {1'b0, occ1};
   assign occ[1] = occ2;
   assign occ[2] = occ3;

   // Beats an instance with k+1 slices may hold
   function automatic int capOf(input int k);
      return SKID ? 2 * (k + 1) : (k + 1);
   endfunction

   // One comparison: counted, and reported when it does not hold
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive every input of the shared stimulus bus
   task automatic applyStimulus(input logic rst, input logic iv, input logic [DW-1:0] d,
                                input logic [CW-1:0] c, input logic ordy, input logic fl);
      reset     = rst;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic resetStats();
      for (int k = 0; k < ND; k++) begin
         accCnt[k]   = 0;
         popCnt[k]   = 0;
         firstAcc[k] = -1;
         lastAcc[k]  = -1;
         firstPop[k] = -1;
         lastPop[k]  = -1;
      end
   endtask

   // Advance one clock: decide transfers from settled pre-edge values, update
   // the scoreboards, then check occupancy after the edge
   task automatic tick();
      logic acc;
      logic pop;
      #2;
      for (int k = 0; k < ND; k++) begin
         acc = !reset && !flush && in_valid && ir[k];
         pop = !reset && !flush && ov[k] && out_ready;
         if (!ov[k])
            checkOutput("bubble_ctrl", 128'(oc[k]), 128'(0));
         if (pop) begin
            if (tail[k] == head[k]) begin
               checkOutput("extra_beat", 128'(1), 128'(0));
            end else begin
               checkOutput("beat_order", 128'({oc[k], od[k]}), 128'(mem[k][head[k] % 16]));
               head[k]++;
            end
            if (popCnt[k] == 0) firstPop[k] = cyc;
            lastPop[k] = cyc;
            popCnt[k]++;
         end
         if (acc) begin
            mem[k][tail[k] % 16] = {in_ctrl, in_data};
            tail[k]++;
            if (accCnt[k] == 0) firstAcc[k] = cyc;
            lastAcc[k] = cyc;
            accCnt[k]++;
         end
         if (reset || flush) begin
            head[k] = 0;
            tail[k] = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < ND; k++) begin
         checkOutput("occupancy", 128'(occ[k]), 128'(tail[k] - head[k]));
         checkOutput("occ_cap", 128'(int'(occ[k]) <= capOf(k)), 128'(1));
      end
   endtask

   // All outputs of every instance at their reset values
   task automatic checkResetState(input string tag);
      for (int k = 0; k < ND; k++) begin
         checkOutput({tag, "_valid"}, 128'(ov[k]), 128'(0));
         checkOutput({tag, "_ctrl"},  128'(oc[k]), 128'(0));
         checkOutput({tag, "_data"},  128'(od[k]), 128'(0));
         checkOutput({tag, "_occ"},   128'(occ[k]), 128'(0));
         checkOutput({tag, "_ready"}, 128'(ir[k]), 128'(0));
      end
   endtask

   logic [95:0]   r96;
   logic [DW-1:0] beatA;
   logic [DW-1:0] beatB;
   int            budget;

   // Directed sequence followed by the randomized scoreboard run
   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      for (int k = 0; k < ND; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
      resetStats();
      beatA = 72'hA5_0123_4567_89AB_CDEF;
      beatB = 72'h5A_FEDC_BA98_7654_3210;

      // Reset held three cycles while upstream offers a beat with all ctrl set
      applyStimulus(1'b1, 1'b1, '0, 5'h1F, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      repeat (3) begin
         checkResetState("reset");
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      for (int k = 0; k < ND; k++)
         checkOutput("ready_at_release", 128'(ir[k]), 128'(0));
      tick();
      for (int k = 0; k < ND; k++)
         checkOutput("ready_after_release", 128'(ir[k]), 128'(1));

      // Back-to-back stream 1..8 with downstream always ready
      $display("[TB] streaming");
      resetStats();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (6) tick();
      for (int k = 0; k < ND; k++) begin
         checkOutput("stream_accepts", 128'(accCnt[k]), 128'(8));
         checkOutput("stream_in_rate", 128'(lastAcc[k] - firstAcc[k]), 128'(7));
         checkOutput("stream_beats", 128'(popCnt[k]), 128'(8));
         checkOutput("stream_latency", 128'(firstPop[k] - firstAcc[k]), 128'(k + 1));
         checkOutput("stream_out_rate", 128'(lastPop[k] - firstPop[k]), 128'(7));
      end

      // Back-pressure on the single-slice instance: offer A then B while stalled
      $display("[TB] back-pressure");
      resetStats();
      applyStimulus(1'b0, 1'b1, beatA, 5'h03, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, beatB, 5'h05, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("bp_ready", 128'(ir[0]), 128'(0));
      checkOutput("bp_occ", 128'(occ[0]), 128'(SKID ? 2 : 1));
      checkOutput("bp_valid", 128'(ov[0]), 128'(1));
      checkOutput("bp_data", 128'(od[0]), 128'(beatA));
      repeat (3) tick();
      checkOutput("bp_hold", 128'(od[0]), 128'(beatA));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (8) tick();
      checkOutput("bp_delivered", 128'(popCnt[0]), 128'(SKID ? 2 : 1));
      checkOutput("bp_empty", 128'(occ[0]), 128'(0));

      // Flush with three ctrl=1F beats held and a beat offered on the same edge
      $display("[TB] flush");
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b1, DW'(16 + i), 5'h1F, 1'b0, 1'b0);
         tick();
      end
      checkOutput("flush_pre_occ", 128'(occ[2]), 128'(3));
      checkOutput("flush_pre_valid", 128'(ov[2]), 128'(1));
      applyStimulus(1'b0, 1'b1, 72'hDEAD, 5'h1F, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < ND; k++) begin
         checkOutput("flush_valid", 128'(ov[k]), 128'(0));
         checkOutput("flush_ctrl", 128'(oc[k]), 128'(0));
         checkOutput("flush_occ", 128'(occ[k]), 128'(0));
      end
      resetStats();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (6) tick();
      checkOutput("flush_no_beat", 128'(popCnt[2]), 128'(0));

      // Reset while beats are in flight, then a clean stream afterwards
      $display("[TB] reset mid-stream");
      applyStimulus(1'b0, 1'b1, 72'h111, 5'h01, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 72'h222, 5'h02, 1'b0, 1'b0);
      tick();
      checkOutput("mid_pre_occ", 128'(occ[1]), 128'(2));
      applyStimulus(1'b1, 1'b1, 72'h333, 5'h1F, 1'b0, 1'b0);
      tick();
      checkResetState("mid_reset");
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      resetStats();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 1'b1, DW'(100 + i), CW'(i), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (6) tick();
      for (int k = 0; k < ND; k++)
         checkOutput("post_reset_beats", 128'(popCnt[k]), 128'(4));

      // Random valid/ready at 50% until 10k beats leave the single-slice instance
      $display("[TB] random traffic");
      resetStats();
      budget = 0;
      while (popCnt[0] < 10000 && budget < 60000) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), r96[DW-1:0],
                       CW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
         tick();
         budget++;
      end
      checkOutput("random_budget", 128'(budget < 60000), 128'(1));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (12) tick();
      for (int k = 0; k < ND; k++) begin
         checkOutput("random_drained", 128'(tail[k] - head[k]), 128'(0));
         checkOutput("random_occ", 128'(occ[k]), 128'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
